// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : input_conditioner
//  Purpose  : Front-end conditioning for the control FSM's two user inputs
//             (I and S). Each raw asynchronous line is brought into the clock
//             domain through a two-flop synchronizer. A stability counter then
//             debounces it. Each channel drives a clean level and a
//             single-cycle pulse on every accepted 0->1 transition.
//  Ports    : inputClk      - system clock, rising edge
//             inputReset    - asynchronous, active-high reset
//             inputRawI/S   - raw lines, asynchronous to inputClk
//             outputI/S     - debounced levels (feed the FSM's inputI/inputS)
//             outputIPulse  - one-cycle pulse on each accepted 0->1 of I
//             outputSPulse  - one-cycle pulse on each accepted 0->1 of S
//  Params   : DEBOUNCE_CYCLES - consecutive synchronized cycles a new level
//                               must persist before it is accepted (>= 1)
//             CNT_W           - counter width, derived; do not override
//  Revision : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic inputClk,
    input  logic inputReset,
    input  logic inputRawI,
    input  logic inputRawS,
    output logic outputI,
    output logic outputS,
    output logic outputIPulse,
    output logic outputSPulse
);

    // Terminal count: a mismatch seen while the counter already holds this
    // value is the DEBOUNCE_CYCLES-th consecutive one, so it is accepted.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               c_NCH      = 2;

    // Channel 0 is I, channel 1 is S.
    logic [c_NCH-1:0] w_raw;
    logic [c_NCH-1:0] w_deb;
    logic [c_NCH-1:0] w_pulse;

    assign w_raw = {inputRawS, inputRawI};

    genvar gi;
    generate
        for (gi = 0; gi < c_NCH; gi++) begin : g_ch
            logic             r_sync1;
            logic             r_sync2;
            logic             r_deb;
            logic             r_pulse;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge inputClk or posedge inputReset) begin
                if (inputReset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_pulse <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    r_pulse <= 1'b0;
                    if (r_sync2 == r_deb) begin
                        // Any agreement discards partial progress, so a
                        // bounce restarts qualification from zero.
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_deb   <= r_sync2;
                        r_cnt   <= '0;
                        // Only a rising acceptance produces a pulse.
                        r_pulse <= r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_deb[gi]   = r_deb;
            assign w_pulse[gi] = r_pulse;
        end
    endgenerate

    // Outputs come straight from flops; no combinational input-to-output path.
    assign outputI      = w_deb[0];
    assign outputS      = w_deb[1];
    assign outputIPulse = w_pulse[0];
    assign outputSPulse = w_pulse[1];

endmodule
`default_nettype wire
